uart_rx: RTL

Asynchronous serial receiver that deserialises 8N1 frames from the `uart_rxd` pin and presents each byte to the UART-to-Wishbone bridge over a valid/ready handshake. It sits directly upstream of the bridge's command parser. It owns input synchronisation, start-bit qualification, mid-bit sampling, stop-bit checking, a one-byte holding register, and error reporting.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_if.sv | 11 +
 rtl/sync2.sv | 21 ++
 rtl/uart_rx.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte valid/ready handshake towards the bridge
interface uart_rx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] data_o;
    logic                      valid_o;
    logic                      ready_i;

    modport master (output data_o, output valid_o, input ready_i);
    modport slave  (input data_o, input valid_o, output ready_i);
endinterface

// File: rtl/sync2.sv
// rtl/sync2.sv - generic 2-flop synchroniser for asynchronous inputs
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with one-byte holding register
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              uart_rxd,
    uart_rx_if.master         rx,
    output logic              frame_err_o,
    output logic              overrun_o,
    output logic              busy_o
);
    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);

    logic       rxd_s;
    logic       rxd_d_q;
    logic [1:0] settle_q;
    logic       fall;

    uart_rx_state_t            state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q, overrun_d;

    sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d     (uart_rxd),
        .q     (rxd_s)
    );

    // The synchroniser's reset value is not a real observation of the pin, so
    // the edge detector stays disarmed until the flops carry genuine samples.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            settle_q <= 2'b00;
            rxd_d_q  <= 1'b0;
        end else begin
            settle_q <= {settle_q[0], 1'b1};
            rxd_d_q  <= rxd_s & settle_q[1];
        end
    end

    assign fall = rxd_d_q & ~rxd_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        if (valid_q && rx.ready_i) valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (fall) begin
                    cnt_d   = CNT_HALF;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (!rxd_s) begin
                        cnt_d   = CNT_FULL;
                        idx_d   = '0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rxd_s, shift_q[UART_DATA_BITS-1:1]};
                    cnt_d   = CNT_FULL;
                    if (idx_q == IDX_LAST) state_d = STOP;
                    else                   idx_d   = idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    if (!rxd_s) begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end else begin
                        // A byte being accepted this cycle frees the slot for the new one.
                        if (!valid_q || rx.ready_i) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            BREAK: begin
                if (rxd_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx.data_o   = data_q;
    assign rx.valid_o  = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != IDLE);
endmodule
